// File: rtl/sample_msg_combiner_if.sv
// sample_msg_combiner_if: sample, message and merged-output signal bundle
interface sample_msg_combiner_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_samples;
    logic             in_samples_nd;
    logic [WIDTH-1:0] in_msg;
    logic             in_msg_nd;
    logic [WIDTH-1:0] out_data;
    logic             out_nd;
    logic             error;

    modport master (
        output in_samples, in_samples_nd, in_msg, in_msg_nd,
        input  out_data, out_nd, error
    );

    modport slave (
        input  in_samples, in_samples_nd, in_msg, in_msg_nd,
        output out_data, out_nd, error
    );
endinterface

// File: rtl/sample_msg_combiner.sv
// sample_msg_combiner: merges a sample stream and a message stream, keeping message packets contiguous
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 8
`endif
module sample_msg_combiner #(
    parameter int WIDTH          = 32,
    parameter int SAMPLE_BUF_LOG = 6,
    parameter int MSG_BUF_LOG    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sample_msg_combiner_if.slave  bus
);
    localparam int LW = `MSG_LENGTH_WIDTH;

    typedef enum logic {IDLE, MSG} state_t;

    state_t                    state, next_state;
    logic [LW-1:0]             remaining, next_remaining;
    logic [WIDTH-1:0]          s_mem [2**SAMPLE_BUF_LOG];
    logic [WIDTH-1:0]          m_mem [2**MSG_BUF_LOG];
    logic [SAMPLE_BUF_LOG-1:0] s_wp, s_rp;
    logic [MSG_BUF_LOG-1:0]    m_wp, m_rp;
    logic [SAMPLE_BUF_LOG:0]   s_cnt;
    logic [MSG_BUF_LOG:0]      m_cnt;
    logic                      s_push, m_push, s_pop, m_pop;
    logic                      emit, arb_err, in_err;
    logic [WIDTH-1:0]          emit_data, m_head;
    logic [LW-1:0]             head_len;
    logic                      head_is_hdr;

    assign m_head      = m_mem[m_rp];
    assign head_is_hdr = m_head[WIDTH-1];
    assign head_len    = m_head[WIDTH-2 -: LW];
    // a full FIFO still takes a word when the arbiter frees a slot on the same edge
    assign s_push = bus.in_samples_nd && !bus.in_samples[WIDTH-1] && (!s_cnt[SAMPLE_BUF_LOG] || s_pop);
    assign m_push = bus.in_msg_nd && (!m_cnt[MSG_BUF_LOG] || m_pop);
    assign in_err = (bus.in_samples_nd && !s_push) || (bus.in_msg_nd && !m_push);

    // arbiter: pending messages win; inside a packet only message words may go out
    always_comb begin
        next_state     = state;
        next_remaining = remaining;
        s_pop          = 1'b0;
        m_pop          = 1'b0;
        emit           = 1'b0;
        emit_data      = m_head;
        arb_err        = 1'b0;
        if (m_cnt != '0) begin
            m_pop = 1'b1;
            if (head_is_hdr) begin
                emit           = 1'b1;
                arb_err        = (state == MSG);
                next_remaining = head_len;
                next_state     = (head_len != '0) ? MSG : IDLE;
            end else if (state == MSG) begin
                emit           = 1'b1;
                next_remaining = remaining - 1'b1;
                next_state     = (remaining == LW'(1)) ? IDLE : MSG;
            end else begin
                arb_err = 1'b1;
            end
        end else if (state == IDLE && s_cnt != '0) begin
            s_pop     = 1'b1;
            emit      = 1'b1;
            emit_data = s_mem[s_rp];
        end
    end

    // state, FIFO pointers, registered output and sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            remaining    <= '0;
            s_wp         <= '0;
            s_rp         <= '0;
            s_cnt        <= '0;
            m_wp         <= '0;
            m_rp         <= '0;
            m_cnt        <= '0;
            bus.out_nd   <= 1'b0;
            bus.out_data <= '0;
            bus.error    <= 1'b0;
        end else begin
            state      <= next_state;
            remaining  <= next_remaining;
            s_wp       <= s_wp + SAMPLE_BUF_LOG'(s_push);
            s_rp       <= s_rp + SAMPLE_BUF_LOG'(s_pop);
            s_cnt      <= s_cnt + (SAMPLE_BUF_LOG+1)'(s_push) - (SAMPLE_BUF_LOG+1)'(s_pop);
            m_wp       <= m_wp + MSG_BUF_LOG'(m_push);
            m_rp       <= m_rp + MSG_BUF_LOG'(m_pop);
            m_cnt      <= m_cnt + (MSG_BUF_LOG+1)'(m_push) - (MSG_BUF_LOG+1)'(m_pop);
            bus.out_nd <= emit;
            if (emit)
                bus.out_data <= emit_data;
            bus.error  <= bus.error | in_err | arb_err;
        end
    end

    // FIFO storage; stale contents are harmless because the pointers define occupancy
    always_ff @(posedge clk) begin
        if (s_push)
            s_mem[s_wp] <= bus.in_samples;
        if (m_push)
            m_mem[m_wp] <= bus.in_msg;
    end
endmodule

// File: tb/tb_sample_msg_combiner.sv
// tb_sample_msg_combiner: random and directed stimulus against a queue-based model of the combiner
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 8
`endif
module tb_sample_msg_combiner;
    localparam int W     = 32;
    localparam int LW    = `MSG_LENGTH_WIDTH;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sample_msg_combiner_if #(.WIDTH(W)) bus();
    sample_msg_combiner #(.WIDTH(W), .SAMPLE_BUF_LOG(6), .MSG_BUF_LOG(6)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int         tests = 0;
    int         fails = 0;
    bit         chk_on = 1'b0;
    logic [W-1:0] sq[$];
    logic [W-1:0] mq[$];
    logic [W-1:0] outs[$];
    bit         in_pkt;
    int         rem;
    logic       exp_nd, exp_err;
    logic [W-1:0] exp_data;

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] hdr(int len, int extra);
        return {1'b1, LW'(len), (W-1-LW)'(extra)};
    endfunction

    function automatic logic [W-1:0] cw(int v);
        return {1'b0, (W-1)'(v)};
    endfunction

    // reference: queues for the two buffers and a packet-remaining count, stepped once per edge
    always @(posedge clk) begin : model
        logic [W-1:0] w;
        int ss, ms;
        bit sp, mp;
        if (!rst_n) begin
            sq.delete();
            mq.delete();
            in_pkt   = 1'b0;
            rem      = 0;
            exp_nd   = 1'b0;
            exp_data = '0;
            exp_err  = 1'b0;
        end else begin
            ss = sq.size();
            ms = mq.size();
            sp = 1'b0;
            mp = 1'b0;
            exp_nd = 1'b0;
            if (ms > 0) begin
                w  = mq.pop_front();
                mp = 1'b1;
                if (w[W-1]) begin
                    if (in_pkt) exp_err = 1'b1;
                    exp_nd   = 1'b1;
                    exp_data = w;
                    rem      = int'(w[W-2 -: LW]);
                    in_pkt   = (rem != 0);
                end else if (in_pkt) begin
                    exp_nd   = 1'b1;
                    exp_data = w;
                    rem--;
                    in_pkt   = (rem != 0);
                end else begin
                    exp_err = 1'b1;
                end
            end else if (!in_pkt && ss > 0) begin
                exp_nd   = 1'b1;
                exp_data = sq.pop_front();
                sp       = 1'b1;
            end
            if (bus.in_samples_nd) begin
                if (bus.in_samples[W-1] || (ss == DEPTH && !sp)) exp_err = 1'b1;
                else sq.push_back(bus.in_samples);
            end
            if (bus.in_msg_nd) begin
                if (ms == DEPTH && !mp) exp_err = 1'b1;
                else mq.push_back(bus.in_msg);
            end
        end
    end

    // every-cycle comparison against the model, plus a log of emitted words
    always @(negedge clk) begin
        if (chk_on) begin
            check("out_nd", W'(bus.out_nd), W'(exp_nd));
            check("error", W'(bus.error), W'(exp_err));
            if (exp_nd) check("out_data", bus.out_data, exp_data);
            if (bus.out_nd) outs.push_back(bus.out_data);
        end
    end

    task automatic step(logic [W-1:0] s, logic snd, logic [W-1:0] m, logic mnd);
        bus.in_samples    = s;
        bus.in_samples_nd = snd;
        bus.in_msg        = m;
        bus.in_msg_nd     = mnd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step('0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        outs.delete();
    endtask

    initial begin
        logic [W-1:0] exp_seq[$];
        int hi, pkt_left;
        rst_n = 1'b0;
        idle(2);
        chk_on = 1'b1;
        check("rst_nd", W'(bus.out_nd), '0);
        check("rst_data", bus.out_data, '0);
        check("rst_err", W'(bus.error), '0);
        rst_n = 1'b1;

        // samples only: two-edge latency, three consecutive strobes
        step(32'h11, 1'b1, '0, 1'b0);
        check("t1_first_nd", W'(bus.out_nd), '0);
        step(32'h22, 1'b1, '0, 1'b0);
        check("t1_w0", bus.out_data, 32'h11);
        check("t1_w0_nd", W'(bus.out_nd), 1);
        step(32'h33, 1'b1, '0, 1'b0);
        check("t1_w1", bus.out_data, 32'h22);
        idle(1);
        check("t1_w2", bus.out_data, 32'h33);
        idle(1);
        check("t1_end_nd", W'(bus.out_nd), '0);
        check("t1_err", W'(bus.error), '0);

        // packet while streaming samples every cycle
        do_reset();
        for (int i = 0; i < 10; i++)
            step(cw(32'h100 + i), 1'b1, (i == 2) ? hdr(3, 0) : cw(32'h500 + i), (i >= 2 && i <= 5));
        idle(20);
        exp_seq = '{cw(32'h100), cw(32'h101), hdr(3, 0), cw(32'h503), cw(32'h504), cw(32'h505)};
        for (int i = 2; i < 10; i++) exp_seq.push_back(cw(32'h100 + i));
        check("t2_count", W'(outs.size()), W'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < outs.size(); i++) check("t2_seq", outs[i], exp_seq[i]);
        check("t2_err", W'(bus.error), '0);

        // slow message: packet stays contiguous in the output
        do_reset();
        for (int i = 0; i < 20; i++)
            step(cw(32'h200 + i), 1'b1, (i == 1) ? hdr(2, 5) : cw(32'h600 + i), (i == 1 || i == 6 || i == 11));
        idle(30);
        check("t3_count", W'(outs.size()), 23);
        hi = 0;
        for (int i = 0; i < outs.size(); i++) if (outs[i] == hdr(2, 5)) hi = i;
        if (hi + 2 < outs.size()) begin
            check("t3_c0", outs[hi+1], cw(32'h606));
            check("t3_c1", outs[hi+2], cw(32'h60b));
        end else check("t3_hdr_pos", W'(hi), W'(outs.size() - 3));
        check("t3_last", outs[outs.size()-1], cw(32'h213));

        // zero-length header then L=1 packet, back-to-back; extra header bits pass through
        do_reset();
        step('0, 1'b0, hdr(0, 32'h12345), 1'b1);
        step('0, 1'b0, hdr(1, 0), 1'b1);
        check("t4_h0", bus.out_data, hdr(0, 32'h12345));
        step('0, 1'b0, cw(32'h7), 1'b1);
        check("t4_h1", bus.out_data, hdr(1, 0));
        step(cw(32'h99), 1'b1, '0, 1'b0);
        check("t4_c", bus.out_data, cw(32'h7));
        idle(1);
        check("t4_idle_sample", bus.out_data, cw(32'h99));
        check("t4_idle_nd", W'(bus.out_nd), 1);

        // faults: bad sample, orphan content, sample overflow during a long packet
        do_reset();
        step(32'h8000_0001, 1'b1, '0, 1'b0);
        idle(1);
        check("t5_bad_sample_err", W'(bus.error), 1);
        check("t5_bad_sample_nd", W'(bus.out_nd), '0);
        do_reset();
        step('0, 1'b0, cw(32'h44), 1'b1);
        idle(1);
        check("t5_orphan_err", W'(bus.error), 1);
        check("t5_orphan_nd", W'(bus.out_nd), '0);
        do_reset();
        step('0, 1'b0, hdr(5, 0), 1'b1);
        for (int i = 0; i < 64; i++) step(cw(32'h300 + i), 1'b1, '0, 1'b0);
        check("t5_full_ok", W'(bus.error), '0);
        step(cw(32'h3ff), 1'b1, '0, 1'b0);
        check("t5_overflow_err", W'(bus.error), 1);
        for (int i = 0; i < 5; i++) step('0, 1'b0, cw(32'h700 + i), 1'b1);
        idle(80);
        check("t5_count", W'(outs.size()), 70);
        check("t5_last", outs[outs.size()-1], cw(32'h33f));

        // reset mid-packet clears everything; a fresh sample flows normally
        do_reset();
        step(32'h8000_0000, 1'b1, hdr(3, 0), 1'b1);
        step(cw(32'h1), 1'b1, cw(32'h2), 1'b1);
        rst_n = 1'b0;
        step(cw(32'h5), 1'b1, cw(32'h3), 1'b1);
        rst_n = 1'b1;
        check("t6_nd", W'(bus.out_nd), '0);
        check("t6_err", W'(bus.error), '0);
        step(cw(32'h77), 1'b1, '0, 1'b0);
        check("t6_empty", W'(bus.out_nd), '0);
        idle(1);
        check("t6_fresh", bus.out_data, cw(32'h77));
        idle(3);
        check("t6_no_more", W'(bus.out_nd), '0);

        // randomized mixed traffic with occasional faults and a mid-run reset
        do_reset();
        pkt_left = -1;
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] s, m;
            logic snd, mnd;
            s   = {($urandom_range(0, 99) == 0), (W-1)'($urandom)};
            snd = ($urandom_range(0, 99) < 45);
            m   = '0;
            mnd = 1'b0;
            if (pkt_left < 0) begin
                if ($urandom_range(0, 99) < 10) begin
                    pkt_left = $urandom_range(0, 6);
                    m   = hdr(pkt_left, $urandom);
                    mnd = 1'b1;
                    if (pkt_left == 0) pkt_left = -1;
                end else if ($urandom_range(0, 199) == 0) begin
                    m   = cw($urandom);
                    mnd = 1'b1;
                end
            end else if ($urandom_range(0, 99) < 60) begin
                m   = cw($urandom);
                mnd = 1'b1;
                pkt_left--;
                if (pkt_left == 0) pkt_left = -1;
            end
            if (i == 1500) begin
                rst_n = 1'b0;
                pkt_left = -1;
            end
            step(s, snd, m, mnd);
            rst_n = 1'b1;
        end
        idle(150);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
